// File: rtl/cdb_arbiter_if.sv
// Producer/consumer bundle of the common data bus: per-source result push
// channels plus the registered broadcast side.
interface cdb_arbiter_if #(
  parameter int N_SRC  = 3,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC-1:0]        src_ready;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC*TAG_W-1:0]  src_tag;
  logic                    cdb_valid;
  logic [DATA_W-1:0]       cdb_data;
  logic [TAG_W-1:0]        cdb_tag;
  logic [SRC_W-1:0]        cdb_src;

  modport master (
    output src_valid, src_data, src_tag,
    input  src_ready, cdb_valid, cdb_data, cdb_tag, cdb_src
  );

  modport slave (
    input  src_valid, src_data, src_tag,
    output src_ready, cdb_valid, cdb_data, cdb_tag, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-producer FIFOs, one registered broadcast per cycle.
// Define CDB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module cdb_arbiter #(
  parameter int N_SRC  = 3,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  cdb_arbiter_if.slave bus
);
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] data_mem_r [N_SRC][DEPTH];
  logic [TAG_W-1:0]  tag_mem_r  [N_SRC][DEPTH];
  logic [PTR_W-1:0]  head_r     [N_SRC];
  logic [PTR_W-1:0]  tail_r     [N_SRC];
  logic [CNT_W-1:0]  count_r    [N_SRC];
  logic [SRC_W-1:0]  rr_ptr_r;

  logic              cdb_valid_r;
  logic [DATA_W-1:0] cdb_data_r;
  logic [TAG_W-1:0]  cdb_tag_r;
  logic [SRC_W-1:0]  cdb_src_r;

  logic [N_SRC-1:0]  ready_s;
  logic [N_SRC-1:0]  push_s;
  logic [N_SRC-1:0]  pop_s;
  logic              grant_found_s;
  logic [SRC_W-1:0]  grant_idx_s;
  logic [SRC_W:0]    sum_v;
  logic [SRC_W:0]    wrap_v;

  // Ready comes only from the registered count, so a full FIFO popped this cycle still reports not-ready.
  always_comb begin
    ready_s = '0;
    push_s  = '0;
    pop_s   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      ready_s[i] = (count_r[i] != CNT_W'(DEPTH));
      push_s[i]  = rdy & ~flush & bus.src_valid[i] & ready_s[i];
      pop_s[i]   = rdy & ~flush & grant_found_s & (grant_idx_s == SRC_W'(i));
    end
  end

  // Round-robin search: first non-empty FIFO at or after rr_ptr, cyclically.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    sum_v         = '0;
    wrap_v        = '0;
    for (int k = 0; k < N_SRC; k++) begin
      sum_v  = {1'b0, rr_ptr_r} + (SRC_W+1)'(k);
      wrap_v = (sum_v >= (SRC_W+1)'(N_SRC)) ? (sum_v - (SRC_W+1)'(N_SRC)) : sum_v;
      if (!grant_found_s && (count_r[wrap_v[SRC_W-1:0]] != '0)) begin
        grant_found_s = 1'b1;
        grant_idx_s   = wrap_v[SRC_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // FIFO storage; contents are don't-care while the matching count is zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (push_s[i]) begin
        data_mem_r[i][tail_r[i]] <= bus.src_data[i*DATA_W +: DATA_W];
        tag_mem_r[i][tail_r[i]]  <= bus.src_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // FIFO pointers, arbitration state and registered broadcast.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        head_r[i]  <= '0;
        tail_r[i]  <= '0;
        count_r[i] <= '0;
      end
      rr_ptr_r    <= '0;
      cdb_valid_r <= 1'b0;
      cdb_data_r  <= '0;
      cdb_tag_r   <= '0;
      cdb_src_r   <= '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < N_SRC; i++) begin
          head_r[i]  <= '0;
          tail_r[i]  <= '0;
          count_r[i] <= '0;
        end
        cdb_valid_r <= 1'b0;
      end else begin
        for (int i = 0; i < N_SRC; i++) begin
          if (push_s[i]) tail_r[i] <= tail_r[i] + PTR_W'(1);
          if (pop_s[i])  head_r[i] <= head_r[i] + PTR_W'(1);
          count_r[i] <= count_r[i] + CNT_W'(push_s[i]) - CNT_W'(pop_s[i]);
        end
        if (grant_found_s) begin
          cdb_valid_r <= 1'b1;
          cdb_data_r  <= data_mem_r[grant_idx_s][head_r[grant_idx_s]];
          cdb_tag_r   <= tag_mem_r[grant_idx_s][head_r[grant_idx_s]];
          cdb_src_r   <= grant_idx_s;
`ifdef CDB_FIXED_PRIO_EN
          rr_ptr_r    <= '0;
`else
          rr_ptr_r    <= (grant_idx_s == SRC_W'(N_SRC-1)) ? '0 : grant_idx_s + SRC_W'(1);
`endif
        end else begin
          cdb_valid_r <= 1'b0;
        end
      end
    end
  end

  assign bus.src_ready = ready_s;
  assign bus.cdb_valid = cdb_valid_r;
  assign bus.cdb_data  = cdb_data_r;
  assign bus.cdb_tag   = cdb_tag_r;
  assign bus.cdb_src   = cdb_src_r;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: accepted pushes are queued per source and
// matched against each broadcast, plus directed checks for latency, flush, pause and reset.
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst, rdy, flush;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_SRC(3), .DATA_W(32), .TAG_W(5)) bus ();

  cdb_arbiter #(.N_SRC(3), .DATA_W(32), .TAG_W(5), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(bus)
  );

  int checks_cnt = 0;
  int errors_cnt = 0;
  logic [63:0] exp_q [3][$];
  logic last_rdy = 1'b0;
  bit   rr_mode = 1'b0;
  bit   fp_mode = 1'b0;
  int   rr_exp = 0;
  int   bcast_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record every push the handshake accepts on this edge.
  always @(posedge clk) begin
    last_rdy <= rdy;
    if (!rst || (rdy && flush)) begin
      for (int i = 0; i < 3; i++) exp_q[i].delete();
    end else if (rdy) begin
      for (int i = 0; i < 3; i++)
        if (bus.src_valid[i] && bus.src_ready[i])
          exp_q[i].push_back({27'b0, bus.src_tag[i*5 +: 5], bus.src_data[i*32 +: 32]});
    end
  end

  // Match each new broadcast against the head of its source queue.
  always @(negedge clk) begin
    int s;
    logic [63:0] e;
    if (rst && bus.cdb_valid && last_rdy) begin
      bcast_cnt++;
      s = int'(bus.cdb_src);
      if (s > 2) chk("cdb_src_range", 64'(s), 64'd0);
      else if (exp_q[s].size() == 0) chk("extra_bcast", 64'(bus.cdb_tag), 64'h1_0000);
      else begin
        e = exp_q[s].pop_front();
        chk("sb_tag", 64'(bus.cdb_tag), 64'(e[36:32]));
        chk("sb_data", 64'(bus.cdb_data), 64'(e[31:0]));
      end
      if (rr_mode) begin
        chk("rr_src", 64'(s), 64'(rr_exp));
        rr_exp = (rr_exp + 1) % 3;
      end
      if (fp_mode) chk("fp_src", 64'(s), 64'd0);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.src_valid = '0;
    flush = 1'b0;
    rdy   = 1'b1;
    rst   = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
  endtask

  // All sources offer n results each, holding while not ready.
  task automatic saturate(input int n, input bit chk_ready);
    int sent [3];
    int guard;
    logic [2:0] acc;
    sent  = '{0, 0, 0};
    guard = 0;
    while ((sent[0] < n || sent[1] < n || sent[2] < n) && guard < 200) begin
      for (int i = 0; i < 3; i++) begin
        bus.src_valid[i]          = (sent[i] < n);
        bus.src_tag[i*5 +: 5]     = 5'(sent[i]);
        bus.src_data[i*32 +: 32]  = {8'(i), 8'hA5, 16'($urandom_range(0, 65535))};
      end
      acc = bus.src_valid & bus.src_ready;
      cycle();
      for (int i = 0; i < 3; i++) if (acc[i]) sent[i]++;
      guard++;
      if (chk_ready && guard == 2) chk("sat_ready", 64'(bus.src_ready), 64'h1);
    end
    bus.src_valid = '0;
    chk("sat_guard", 64'(guard < 200), 64'd1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && g < 60) begin
      cycle();
      g++;
    end
    chk("drain_empty", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    bus.src_valid = '0; bus.src_data = '0; bus.src_tag = '0;
    #2;
    chk("rst_valid", 64'(bus.cdb_valid), 64'd0);
    chk("rst_ready", 64'(bus.src_ready), 64'h7);
    chk("rst_data",  64'(bus.cdb_data),  64'd0);
    chk("rst_tag",   64'(bus.cdb_tag),   64'd0);
    chk("rst_src",   64'(bus.cdb_src),   64'd0);
    repeat (2) cycle();
    rst = 1'b1;
    cycle();

    // Single source latency
    bus.src_valid = 3'b001;
    bus.src_tag[4:0] = 5'd3;
    bus.src_data[31:0] = 32'hDEADBEEF;
    cycle();
    bus.src_valid = '0;
    chk("lat_no_bypass", 64'(bus.cdb_valid), 64'd0);
    cycle();
    chk("lat_valid", 64'(bus.cdb_valid), 64'd1);
    chk("lat_tag",   64'(bus.cdb_tag),   64'd3);
    chk("lat_data",  64'(bus.cdb_data),  64'hDEADBEEF);
    chk("lat_src",   64'(bus.cdb_src),   64'd0);
    cycle();
    chk("lat_once",  64'(bus.cdb_valid), 64'd0);

    // Reset asserted mid-operation
    saturate(4, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.cdb_valid), 64'd0);
    chk("arst_ready", 64'(bus.src_ready), 64'h7);
    chk("arst_tag",   64'(bus.cdb_tag),   64'd0);
    repeat (2) cycle();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("arst_quiet", 64'(bus.cdb_valid), 64'd0);
    end

    // Round-robin under saturation
    do_reset();
    bcast_cnt = 0;
    rr_exp = 0;
`ifndef CDB_FIXED_PRIO_EN
    rr_mode = 1'b1;
`endif
    saturate(8, 1'b1);
    drain();
    rr_mode = 1'b0;
    chk("sat_count", 64'(bcast_cnt), 64'd24);

    // Flush with a same-cycle push of tag 9
    do_reset();
    bus.src_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      bus.src_tag[i*5 +: 5] = 5'(i + 1);
      bus.src_data[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    end
    cycle();
    bus.src_valid = 3'b101;
    cycle();
    chk("fl_ready_pre", 64'(bus.src_ready), 64'h3);
    flush = 1'b1;
    bus.src_valid = 3'b010;
    bus.src_tag[9:5] = 5'd9;
    cycle();
    flush = 1'b0;
    bus.src_valid = '0;
    chk("fl_valid", 64'(bus.cdb_valid), 64'd0);
    chk("fl_ready", 64'(bus.src_ready), 64'h7);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("fl_quiet", 64'(bus.cdb_valid), 64'd0);
    end

    // Pause with a broadcast on the bus and entries pending
    do_reset();
    bus.src_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      bus.src_tag[i*5 +: 5] = 5'(i + 4);
      bus.src_data[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
    end
    cycle();
    bus.src_valid = '0;
    cycle();
    chk("pz_tag0", 64'(bus.cdb_tag), 64'd4);
    rdy = 1'b0;
    bus.src_valid = 3'b001;
    bus.src_tag[4:0] = 5'd7;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("pz_valid", 64'(bus.cdb_valid), 64'd1);
      chk("pz_tag",   64'(bus.cdb_tag),   64'd4);
      chk("pz_src",   64'(bus.cdb_src),   64'd0);
      chk("pz_ready", 64'(bus.src_ready), 64'h7);
    end
    bus.src_valid = '0;
    rdy = 1'b1;
    cycle();
    chk("pz_resume_tag", 64'(bus.cdb_tag), 64'd5);
    chk("pz_resume_src", 64'(bus.cdb_src), 64'd1);
    drain();

`ifdef CDB_FIXED_PRIO_EN
    // Fixed priority: src0 keeps winning while it stays non-empty
    do_reset();
    fp_mode = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.src_valid = 3'b101;
      bus.src_tag[4:0] = 5'(k);
      bus.src_tag[14:10] = 5'(k + 16);
      bus.src_data[31:0] = 32'hF000_0000 + 32'(k);
      bus.src_data[95:64] = 32'hF200_0000 + 32'(k);
      cycle();
    end
    bus.src_valid = '0;
    cycle();
    #5;
    fp_mode = 1'b0;
    drain();
`endif

    repeat (3) cycle();
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
